// File: rtl/drs_event_packetizer.sv
// -----------------------------------------------------------------------------
// drs_event_packetizer
//
// Turns one DRS event into a framed 16-bit stream packet:
//   HEADER  : 0xAAAA, event counter (hi, lo), timestamp (hi, mid, lo),
//             {5'b0, sample_count}, {7'b0, channel_mask}
//   PAYLOAD : popcount(channel_mask) * sample_count words taken straight from
//             the first-word-fall-through readout FIFO
//   CRC     : CRC-16-CCITT over every word after 0xAAAA up to the last
//             payload word (only when DRS_PACKET_CRC_EN is defined)
//   TRAILER : 0x5555 with m_last_o
//
// Optional feature macro: DRS_PACKET_CRC_EN (undefined by default, in which
// case the CRC state, register and update logic are not built).
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   event_ready_i/ack_o    descriptor handshake (level request, 1-cycle ack)
//   event_counter_i        32-bit event number
//   timestamp_i            48-bit trigger timestamp
//   sample_count_i         samples per channel (clamped to MAX_SAMPLES)
//   channel_mask_i         9-bit mask of channels read out
//   fifo_data_i/empty_i    FWFT readout FIFO head word and empty flag
//   fifo_rd_en_o           FIFO pop (combinational, only in PAYLOAD)
//   m_data_o/valid_o/ready_i/last_o   output stream
//   busy_o                 high whenever a packet is in progress
// -----------------------------------------------------------------------------
module drs_event_packetizer #(
    parameter int MAX_SAMPLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        event_ready_i,
    output logic        event_ack_o,
    input  logic [31:0] event_counter_i,
    input  logic [47:0] timestamp_i,
    input  logic [10:0] sample_count_i,
    input  logic [8:0]  channel_mask_i,
    input  logic [15:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    output logic [15:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        m_last_o,
    output logic        busy_o
);

`ifdef DRS_PACKET_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_TRAILER = 3'd4
    } state_t;
    localparam state_t ST_AFTER_PAYLOAD = ST_CRC;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_TRAILER = 3'd4
    } state_t;
    localparam state_t ST_AFTER_PAYLOAD = ST_TRAILER;
`endif

    localparam logic [10:0] LP_MAX_SAMPLES = 11'(MAX_SAMPLES);

    // Number of channels enabled in the mask.
    function automatic logic [3:0] popcount9(input logic [8:0] mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'd0, mask[i]};
        end
        return cnt;
    endfunction

`ifdef DRS_PACKET_CRC_EN
    // CRC-16-CCITT (poly 0x1021), one 16-bit word, MSB first, no reflection.
    function automatic logic [15:0] crc16_ccitt_word(input logic [15:0] crc_in,
                                                     input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_event_counter;
    logic [47:0] r_timestamp;
    logic [10:0] r_sample_count;
    logic [8:0]  r_channel_mask;
    logic [2:0]  r_hdr_idx;
    logic [14:0] r_pay_cnt;
`ifdef DRS_PACKET_CRC_EN
    logic [15:0] r_crc;
`endif

    logic [10:0] w_sample_count;
    logic [14:0] w_pay_len;
    logic [15:0] w_hdr_word;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_last;
    logic        w_accept;
    logic        w_xfer;

    // Larger requests than the block is sized for are clamped on entry.
    assign w_sample_count = (sample_count_i > LP_MAX_SAMPLES) ? LP_MAX_SAMPLES : sample_count_i;

    // At most 9 * 1024 = 9216 payload words, so 15 bits never overflows.
    assign w_pay_len = {11'd0, popcount9(r_channel_mask)} * {4'd0, r_sample_count};

    assign w_xfer = w_valid & m_ready_i;

    // Header word selected by the header word index.
    always_comb begin
        w_hdr_word = 16'h0000;
        case (r_hdr_idx)
            3'd0:    w_hdr_word = 16'hAAAA;
            3'd1:    w_hdr_word = r_event_counter[31:16];
            3'd2:    w_hdr_word = r_event_counter[15:0];
            3'd3:    w_hdr_word = r_timestamp[47:32];
            3'd4:    w_hdr_word = r_timestamp[31:16];
            3'd5:    w_hdr_word = r_timestamp[15:0];
            3'd6:    w_hdr_word = {5'd0, r_sample_count};
            3'd7:    w_hdr_word = {7'd0, r_channel_mask};
            default: w_hdr_word = 16'h0000;
        endcase
    end

    // Next-state and stream output decode. Outputs only change on a transfer,
    // so data and last stay stable while the sink back-pressures.
    always_comb begin
        w_next_state = r_state;
        w_data       = 16'h0000;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (event_ready_i && !reset) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_HEADER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HEADER: begin
                w_valid = 1'b1;
                w_data  = w_hdr_word;
                if (m_ready_i && (r_hdr_idx == 3'd7)) begin
                    if (w_pay_len == 15'd0) begin
                        w_next_state = ST_AFTER_PAYLOAD;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end else begin
                    w_next_state = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                // Empty FIFO simply stalls; no timeout by design.
                w_valid = !fifo_empty_i;
                w_data  = fifo_data_i;
                if (!fifo_empty_i && m_ready_i && ((r_pay_cnt + 15'd1) == w_pay_len)) begin
                    w_next_state = ST_AFTER_PAYLOAD;
                end else begin
                    w_next_state = ST_PAYLOAD;
                end
            end
`ifdef DRS_PACKET_CRC_EN
            ST_CRC: begin
                w_valid = 1'b1;
                w_data  = r_crc;
                if (m_ready_i) begin
                    w_next_state = ST_TRAILER;
                end else begin
                    w_next_state = ST_CRC;
                end
            end
`endif
            ST_TRAILER: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = 16'h5555;
                if (m_ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_TRAILER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, descriptor latch, header/payload counters and running CRC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_event_counter <= 32'd0;
            r_timestamp     <= 48'd0;
            r_sample_count  <= 11'd0;
            r_channel_mask  <= 9'd0;
            r_hdr_idx       <= 3'd0;
            r_pay_cnt       <= 15'd0;
`ifdef DRS_PACKET_CRC_EN
            r_crc           <= 16'd0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_event_counter <= event_counter_i;
                r_timestamp     <= timestamp_i;
                r_sample_count  <= w_sample_count;
                r_channel_mask  <= channel_mask_i;
                r_hdr_idx       <= 3'd0;
                r_pay_cnt       <= 15'd0;
`ifdef DRS_PACKET_CRC_EN
                r_crc           <= 16'hFFFF;
`endif
            end else begin
                if (w_xfer && (r_state == ST_HEADER)) begin
                    r_hdr_idx <= r_hdr_idx + 3'd1;
                end
                if (w_xfer && (r_state == ST_PAYLOAD)) begin
                    r_pay_cnt <= r_pay_cnt + 15'd1;
                end
`ifdef DRS_PACKET_CRC_EN
                // The 0xAAAA sync word is excluded from the CRC.
                if (w_xfer && (((r_state == ST_HEADER) && (r_hdr_idx != 3'd0)) ||
                               (r_state == ST_PAYLOAD))) begin
                    r_crc <= crc16_ccitt_word(r_crc, w_data);
                end
`endif
            end
        end
    end

    assign event_ack_o  = w_accept;
    assign fifo_rd_en_o = (r_state == ST_PAYLOAD) && w_xfer;
    assign m_data_o     = w_data;
    assign m_valid_o    = w_valid;
    assign m_last_o     = w_last;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: doc/drs_event_packetizer.md
DRS_EVENT_PACKETIZER -- requirements
Module: drs_event_packetizer

Interface
REQ-001 SHALL have parameter MAX_SAMPLES, default 1024, giving the maximum samples per channel accepted.
REQ-002 SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port event_ready_i  input  1  the event descriptor is valid; level, held until acknowledged.
REQ-005 SHALL have port event_ack_o  output  1  one-cycle pulse when the descriptor is latched.
REQ-006 SHALL have port event_counter_i  input  32  event number.
REQ-007 SHALL have port timestamp_i  input  48  trigger timestamp.
REQ-008 SHALL have port sample_count_i  input  11  samples per channel, 0..MAX_SAMPLES.
REQ-009 SHALL have port channel_mask_i  input  9  channels read out.
REQ-010 SHALL have port fifo_data_i  input  16  DRS readout FIFO word, first-word-fall-through.
REQ-011 SHALL have port fifo_empty_i  input  1  FIFO empty.
REQ-012 SHALL have port fifo_rd_en_o  output  1  FIFO pop, combinational.
REQ-013 SHALL have port m_data_o  output  16  stream data.
REQ-014 SHALL have port m_valid_o  output  1  stream valid.
REQ-015 SHALL have port m_ready_i  input  1  stream ready.
REQ-016 SHALL have port m_last_o  output  1  final word of packet.
REQ-017 SHALL have port busy_o  output  1  high in any state except IDLE.

Function
REQ-018 SHALL implement states IDLE, HEADER, PAYLOAD, CRC, TRAILER.
- IDLE -> HEADER when event_ready_i=1: latch all descriptor inputs; pulse event_ack_o in the same cycle.
REQ-019 SHALL emit HEADER words in this order:
- 0xAAAA
- event_counter[31:16], event_counter[15:0]
- timestamp[47:32], timestamp[31:16], timestamp[15:0]
- {5'b0, sample_count}
- {7'b0, channel_mask}
REQ-020 SHALL compute payload length = popcount(channel_mask) x sample_count at 15-bit width; when the length is 0, HEADER -> CRC directly.
REQ-021 In PAYLOAD, SHALL drive m_data_o=fifo_data_i and m_valid_o=!fifo_empty_i.
- fifo_rd_en_o = m_valid_o & m_ready_i.
- fifo_rd_en_o SHALL be 0 in all other states.
REQ-022 SHALL hold a 15-bit payload counter; PAYLOAD -> CRC on the transfer that brings it to the payload length.
REQ-023 SHALL emit the TRAILER word 0x5555 with m_last_o=1, then return to IDLE.
REQ-024 A word transfers only when m_valid_o & m_ready_i; while m_valid_o=1 & m_ready_i=0, m_data_o and m_last_o SHALL be held stable.
REQ-025 Outside PAYLOAD, m_valid_o SHALL be 1 in every non-IDLE state.
REQ-026 An empty FIFO mid-payload SHALL stall with no timeout and no word lost or duplicated.
REQ-027 event_ready_i SHALL be ignored when not in IDLE; a new descriptor is accepted at the earliest one cycle after TRAILER transfers.
REQ-028 Every transferred word SHALL add zero bubble cycles when m_ready_i=1 and the FIFO is non-empty.

Reset
REQ-029 On reset, SHALL set: state=IDLE, event_ack_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0, fifo_rd_en_o=0, counters and CRC cleared.
REQ-030 Reset mid-packet SHALL abandon the packet without emitting m_last_o; the FIFO is not drained by this block.

Configuration
REQ-031 Macro DRS_PACKET_CRC_EN SHALL, when defined, insert a CRC word between the last payload word and the TRAILER.
- CRC algorithm: CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
- CRC covers all transferred words after 0xAAAA through the last payload word, updated one word per transfer.
REQ-032 When DRS_PACKET_CRC_EN is undefined, the CRC state and logic SHALL be absent and the flow SHALL be HEADER/PAYLOAD -> TRAILER.

Verification
REQ-033 mask=0x001, sample_count=4, FIFO holding 1,2,3,4, m_ready_i=1 -> 14 words (CRC_EN) back-to-back; last word 0x5555 with m_last_o=1.
REQ-034 mask=0x000, sample_count=1024 -> HEADER, CRC (if enabled), TRAILER; fifo_rd_en_o never asserted.
REQ-035 mask=0x1FF, sample_count=1024, m_ready_i toggling every cycle -> exactly 9216 FIFO pops; data stable during stalls.
REQ-036 FIFO empty for 50 cycles after payload word 3 -> m_valid_o low for 50 cycles; then resumes with word 4, no duplicates.
REQ-037 reset asserted during payload word 100 -> next cycle: IDLE, m_valid_o=0; the next event produces a correct packet starting with 0xAAAA.
REQ-038 CRC_EN, header-only packet with event_counter=0x00000001, timestamp=0, sample_count=0, mask=0 -> CRC word equals the reference-model CCITT value over those 7 words.
